angle_read_scheduler: RTL and testbench
=======================================

Name: angle_read_scheduler

Overview:
- Periodic sequencer for the I2C register-read controller that samples the magnetic encoder's raw-angle register.
- Issues one-cycle start pulses at a fixed sample period and captures the 16-bit register result.
- Delivers a validated 12-bit angle with a valid strobe, and runs a timeout watchdog and consecutive-failure error tracking.
- Sits between the I2C reader and the FOC angle/speed logic.

Parameters:
- PERIOD, 24'd100000: clocks from one start pulse to the earliest next start pulse; values 0 and 1 mean back-to-back.
- TIMEOUT, 24'd20000: clocks allowed in BUSY before a read is declared failed.
- MAX_FAIL, 4'd3: consecutive failures that assert err; 0 is treated as 1.

Ports:
- clk, input, 1: clock.
- rst, input, 1: reset, asynchronous, active-high.
- en, input, 1: sampling enable.
- i2c_start, output, 1: one-cycle start pulse to the I2C reader.
- i2c_ready, input, 1: reader idle.
- i2c_done, input, 1: reader one-cycle completion pulse.
- i2c_regout, input, 16: reader result.
- angle, output, 12: last good angle.
- angle_valid, output, 1: one-cycle strobe, angle updated.
- angle_delta, output, 13: signed wrapped delta (optional feature).
- err, output, 1: consecutive-failure alarm.
- fail_cnt, output, 4: consecutive failures, saturating at 15.

Behaviour:
- Reset values: all outputs 0; state IDLE; period counter 0; timeout counter 0.
- All outputs are registered.
- IDLE:
  - en=0 stays IDLE.
  - en=1 goes to WAIT_RDY.
- WAIT_RDY:
  - On a cycle with i2c_ready=1, raise i2c_start for exactly the next cycle.
  - On that same transition, clear the period counter and the timeout counter, then enter BUSY.
  - i2c_done seen in WAIT_RDY is stale and ignored.
- BUSY: timeout counter increments each cycle.
  - On i2c_done=1 with i2c_regout[15:12]==0 (good read):
    - Next cycle: angle=i2c_regout[11:0], angle_valid=1 for one cycle.
    - fail_cnt cleared, err cleared.
  - On i2c_done=1 with i2c_regout[15:12]!=0 (format fail): angle is unchanged, no strobe, counted as a failure.
  - If the timeout counter reaches TIMEOUT-1 without i2c_done (timeout fail): counted as a failure.
  - A failure increments fail_cnt (saturating at 15). err is set when fail_cnt reaches MAX_FAIL and stays set until the next good read.
  - After good, format or timeout: enter HOLD.
  - i2c_done and timeout expiry in the same cycle: i2c_done wins.
- HOLD:
  - The period counter runs from the start pulse and saturates at PERIOD-1.
  - When it reaches PERIOD-1 (or immediately if PERIOD<=1): en=1 goes to WAIT_RDY, en=0 goes to IDLE.
  - If a read outlasts PERIOD, the next start is issued as soon as the reader is ready again. No catch-up bursts.
- en falling in WAIT_RDY: return to IDLE, no start issued.
- en falling in BUSY: the current read completes and is captured normally, then HOLD, then IDLE.
- i2c_start is never asserted outside the WAIT_RDY→BUSY transition. It is never asserted on two consecutive cycles.
- Reset mid-operation: immediate return to the reset values. The I2C reader is not aborted; its late i2c_done lands in IDLE/WAIT_RDY and is ignored.
- Latency: i2c_done at cycle N gives angle/angle_valid at N+1.

Optional Feature:
- Macro: ANGLE_READ_SCHED_DELTA_EN.
- Defined:
  - On each good read after the first good read since reset, angle_delta = signed (new − previous) mod 4096, mapped to the range −2048..+2047 and sign-extended to 13 bits. It updates in the same cycle as angle_valid.
  - The first good read after reset sets angle_delta=0.
  - Failed reads do not update the previous-angle register.
- Undefined: angle_delta is constant 0. Its port remains for interface stability.

Test Plan:
- PERIOD=100, reader model returns 16'h0123 40 cycles after start → i2c_start pulses are exactly 100 cycles apart; angle=12'h123 with a one-cycle angle_valid the cycle after each i2c_done.
- Reader returns 16'hF123 three consecutive times, MAX_FAIL=3 → no angle_valid; fail_cnt 1,2,3; err rises on the 3rd failure; next read 16'h0456 → angle=12'h456, err=0, fail_cnt=0.
- Reader never pulses i2c_done, TIMEOUT=50 → failure registered 50 cycles after start; a late done arriving in WAIT_RDY is ignored; fail_cnt=1.
- en dropped mid-BUSY → read still captured, no further i2c_start; en dropped in WAIT_RDY with i2c_ready=0 → no start, state IDLE.
- rst asserted mid-BUSY → all outputs 0 asynchronously; after release with en=1, the first start is issued only when i2c_ready=1.
- DELTA_EN: good reads of 12'hFF0 then 12'h010 → angle_delta=+32; then 12'hFF0 → −32; the first read after reset gives 0.

Source files
------------

// File: rtl/angle_read_scheduler.sv
// angle_read_scheduler: periodic raw-angle read sequencer for the I2C reader, with timeout
// watchdog and consecutive-failure alarm. Define ANGLE_READ_SCHED_DELTA_EN for the angle_delta output.
module angle_read_scheduler #(
  parameter logic [23:0] PERIOD   = 24'd100000,
  parameter logic [23:0] TIMEOUT  = 24'd20000,
  parameter logic [3:0]  MAX_FAIL = 4'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  output logic        i2c_start,
  input  logic        i2c_ready,
  input  logic        i2c_done,
  input  logic [15:0] i2c_regout,
  output logic [11:0] angle,
  output logic        angle_valid,
  output logic [12:0] angle_delta,
  output logic        err,
  output logic [3:0]  fail_cnt
);

  localparam logic [23:0] PERIOD_LAST  = (PERIOD > 24'd1) ? (PERIOD - 24'd1) : 24'd0;
  localparam logic [23:0] TIMEOUT_LAST = (TIMEOUT > 24'd1) ? (TIMEOUT - 24'd1) : 24'd0;
  localparam logic [3:0]  FAIL_LIMIT   = (MAX_FAIL == 4'd0) ? 4'd1 : MAX_FAIL;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_RDY = 2'd1,
    BUSY     = 2'd2,
    HOLD     = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [23:0] period_cnt_q, period_cnt_d;
  logic [23:0] timeout_cnt_q, timeout_cnt_d;
  logic        start_q, start_d;
  logic [11:0] angle_q, angle_d;
  logic        valid_q, valid_d;
  logic        err_q, err_d;
  logic [3:0]  fail_cnt_q, fail_cnt_d;
  logic [3:0]  fail_inc;
  logic        good_read;
  logic        hold_done;

  always_comb begin
    state_d       = state_q;
    period_cnt_d  = (period_cnt_q < PERIOD_LAST) ? (period_cnt_q + 24'd1) : period_cnt_q;
    timeout_cnt_d = timeout_cnt_q;
    start_d       = 1'b0;
    angle_d       = angle_q;
    valid_d       = 1'b0;
    err_d         = err_q;
    fail_cnt_d    = fail_cnt_q;
    good_read     = 1'b0;
    fail_inc      = (fail_cnt_q == 4'd15) ? 4'd15 : (fail_cnt_q + 4'd1);
    // Leave HOLD so that WAIT_RDY coincides with the counter reaching PERIOD-1,
    // which puts consecutive start pulses exactly PERIOD clocks apart.
    hold_done     = (({1'b0, period_cnt_q} + 25'd1) >= {1'b0, PERIOD_LAST});

    case (state_q)
      IDLE: begin
        if (en) state_d = WAIT_RDY;
      end
      WAIT_RDY: begin
        if (!en) begin
          state_d = IDLE;
        end else if (i2c_ready) begin
          start_d       = 1'b1;
          period_cnt_d  = 24'd0;
          timeout_cnt_d = 24'd0;
          state_d       = BUSY;
        end
      end
      BUSY: begin
        timeout_cnt_d = timeout_cnt_q + 24'd1;
        if (i2c_done) begin
          state_d = HOLD;
          if (i2c_regout[15:12] == 4'd0) begin
            good_read  = 1'b1;
            angle_d    = i2c_regout[11:0];
            valid_d    = 1'b1;
            fail_cnt_d = 4'd0;
            err_d      = 1'b0;
          end else begin
            fail_cnt_d = fail_inc;
            err_d      = err_q | (fail_inc >= FAIL_LIMIT);
          end
        end else if (timeout_cnt_q >= TIMEOUT_LAST) begin
          state_d    = HOLD;
          fail_cnt_d = fail_inc;
          err_d      = err_q | (fail_inc >= FAIL_LIMIT);
        end
      end
      HOLD: begin
        if (hold_done) state_d = en ? WAIT_RDY : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      period_cnt_q  <= 24'd0;
      timeout_cnt_q <= 24'd0;
      start_q       <= 1'b0;
      angle_q       <= 12'd0;
      valid_q       <= 1'b0;
      err_q         <= 1'b0;
      fail_cnt_q    <= 4'd0;
    end else begin
      state_q       <= state_d;
      period_cnt_q  <= period_cnt_d;
      timeout_cnt_q <= timeout_cnt_d;
      start_q       <= start_d;
      angle_q       <= angle_d;
      valid_q       <= valid_d;
      err_q         <= err_d;
      fail_cnt_q    <= fail_cnt_d;
    end
  end

  assign i2c_start   = start_q;
  assign angle       = angle_q;
  assign angle_valid = valid_q;
  assign err         = err_q;
  assign fail_cnt    = fail_cnt_q;

`ifdef ANGLE_READ_SCHED_DELTA_EN
  logic        have_prev_q, have_prev_d;
  logic [12:0] delta_q, delta_d;
  logic [11:0] diff;

  // angle_q always holds the previous good angle, so it doubles as the reference.
  always_comb begin
    diff        = i2c_regout[11:0] - angle_q;
    have_prev_d = have_prev_q;
    delta_d     = delta_q;
    if (good_read) begin
      have_prev_d = 1'b1;
      delta_d     = have_prev_q ? {diff[11], diff} : 13'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      have_prev_q <= 1'b0;
      delta_q     <= 13'd0;
    end else begin
      have_prev_q <= have_prev_d;
      delta_q     <= delta_d;
    end
  end

  assign angle_delta = delta_q;
`else
  assign angle_delta = 13'd0;
`endif

endmodule

// File: tb/tb_angle_read_scheduler.sv
// Self-checking bench for angle_read_scheduler: table-driven read transactions scored
// through an expectation queue, plus hand-written timeout, enable and reset sequences.
module tb_angle_read_scheduler;

`ifdef ANGLE_READ_SCHED_DELTA_EN
  localparam bit DELTA_ON = 1'b1;
`else
  localparam bit DELTA_ON = 1'b0;
`endif

  typedef struct {
    logic        valid;
    logic [11:0] angle;
    logic [3:0]  fcnt;
    logic        err;
    int          delta;
  } exp_t;

  typedef struct {
    int   due;
    exp_t e;
  } sb_t;

  typedef struct {
    logic [15:0] regout;
    exp_t        e;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        i2c_start;
  logic        i2c_ready;
  logic        i2c_done;
  logic [15:0] i2c_regout;
  logic [11:0] angle;
  logic        angle_valid;
  logic [12:0] angle_delta;
  logic        err;
  logic [3:0]  fail_cnt;

  int  n_checks = 0;
  int  n_fail = 0;
  int  cyc = 0;
  int  start_count = 0;
  bit  prev_start = 1'b0;
  sb_t sb[$];

  angle_read_scheduler #(
    .PERIOD  (24'd100),
    .TIMEOUT (24'd50),
    .MAX_FAIL(4'd3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .i2c_start  (i2c_start),
    .i2c_ready  (i2c_ready),
    .i2c_done   (i2c_done),
    .i2c_regout (i2c_regout),
    .angle      (angle),
    .angle_valid(angle_valid),
    .angle_delta(angle_delta),
    .err        (err),
    .fail_cnt   (fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t mk(input logic v, input logic [11:0] a, input logic [3:0] f,
                              input logic e, input int d);
    exp_t r;
    r.valid = v;
    r.angle = a;
    r.fcnt  = f;
    r.err   = e;
    r.delta = DELTA_ON ? d : 0;
    return r;
  endfunction

  // Scoreboard and protocol monitor, sampled on the falling edge.
  initial begin
    sb_t it;
    forever begin
      @(negedge clk);
      if (i2c_start) begin
        if (prev_start) checkOutput("start_back_to_back", 1, 0);
        start_count++;
      end
      prev_start = i2c_start;
      if (sb.size() > 0 && sb[0].due <= cyc) begin
        it = sb.pop_front();
        checkOutput("sb_valid", int'(angle_valid), int'(it.e.valid));
        checkOutput("sb_angle", int'(angle), int'(it.e.angle));
        checkOutput("sb_fail_cnt", int'(fail_cnt), int'(it.e.fcnt));
        checkOutput("sb_err", int'(err), int'(it.e.err));
        checkOutput("sb_delta", int'($signed(angle_delta)), it.e.delta);
      end else if (angle_valid) begin
        checkOutput("spurious_valid", 1, 0);
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic wait_start(output int s, output bit ok);
    ok = 1'b0;
    s  = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clk);
      if (i2c_start) begin
        ok = 1'b1;
        s  = cyc;
      end
    end
    checkOutput("start_issued", int'(ok), 1);
  endtask

  task automatic respond(input logic [15:0] val, input int lat, input exp_t e);
    sb_t it;
    i2c_ready = 1'b0;
    repeat (lat) @(negedge clk);
    i2c_done   = 1'b1;
    i2c_regout = val;
    it.due = cyc + 1;
    it.e   = e;
    sb.push_back(it);
    @(negedge clk);
    i2c_done  = 1'b0;
    i2c_ready = 1'b1;
  endtask

  task automatic applyStimulus(input logic [15:0] val, input int lat, input exp_t e,
                               output int s);
    bit ok;
    wait_start(s, ok);
    if (ok) respond(val, lat, e);
  endtask

  initial begin
    vec_t tbl[9];
    int   starts[4];
    int   s;
    int   n0;
    bit   ok;
    sb_t  it;

    tbl[0] = '{16'hF123, mk(1'b0, 12'h123, 4'd1, 1'b0, 0)};
    tbl[1] = '{16'hF123, mk(1'b0, 12'h123, 4'd2, 1'b0, 0)};
    tbl[2] = '{16'hF123, mk(1'b0, 12'h123, 4'd3, 1'b1, 0)};
    tbl[3] = '{16'h0456, mk(1'b1, 12'h456, 4'd0, 1'b0, 819)};
    tbl[4] = '{16'h0FF0, mk(1'b1, 12'hFF0, 4'd0, 1'b0, -1126)};
    tbl[5] = '{16'h0010, mk(1'b1, 12'h010, 4'd0, 1'b0, 32)};
    tbl[6] = '{16'h0FF0, mk(1'b1, 12'hFF0, 4'd0, 1'b0, -32)};
    tbl[7] = '{16'h8000, mk(1'b0, 12'hFF0, 4'd1, 1'b0, -32)};
    tbl[8] = '{16'h0000, mk(1'b1, 12'h000, 4'd0, 1'b0, 16)};

    rst        = 1'b1;
    en         = 1'b0;
    i2c_ready  = 1'b1;
    i2c_done   = 1'b0;
    i2c_regout = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("reset_start", int'(i2c_start), 0);
    checkOutput("reset_angle", int'(angle), 0);
    checkOutput("reset_valid", int'(angle_valid), 0);
    checkOutput("reset_delta", int'(angle_delta), 0);
    checkOutput("reset_err", int'(err), 0);
    checkOutput("reset_fail_cnt", int'(fail_cnt), 0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] periodic reads of 16'h0123, 40-cycle reader latency");
    en = 1'b1;
    for (int k = 0; k < 4; k++)
      applyStimulus(16'h0123, 40, mk(1'b1, 12'h123, 4'd0, 1'b0, 0), starts[k]);
    for (int k = 1; k < 4; k++)
      checkOutput("start_spacing", starts[k] - starts[k-1], 100);

    $display("[TB] table of format-fail and good reads");
    for (int i = 0; i < 9; i++)
      applyStimulus(tbl[i].regout, 20, tbl[i].e, s);

    $display("[TB] reader timeout then stale done in WAIT_RDY");
    wait_start(s, ok);
    i2c_ready = 1'b0;
    it.due = s + 50;
    it.e   = mk(1'b0, 12'h000, 4'd1, 1'b0, 16);
    sb.push_back(it);
    while (cyc < s + 49) @(negedge clk);
    checkOutput("timeout_not_early", int'(fail_cnt), 0);
    while (cyc < s + 110) @(negedge clk);
    n0 = start_count;
    i2c_done   = 1'b1;
    i2c_regout = 16'h0789;
    @(negedge clk);
    i2c_done = 1'b0;
    checkOutput("stale_done_angle", int'(angle), 0);
    checkOutput("stale_done_fail_cnt", int'(fail_cnt), 1);
    checkOutput("no_start_while_not_ready", start_count, n0);

    $display("[TB] enable dropped during BUSY");
    i2c_ready = 1'b1;
    wait_start(s, ok);
    if (ok) begin
      i2c_ready = 1'b0;
      @(negedge clk);
      en = 1'b0;
      respond(16'h0321, 10, mk(1'b1, 12'h321, 4'd0, 1'b0, 801));
    end
    n0 = start_count;
    repeat (200) @(negedge clk);
    checkOutput("no_start_after_en_drop", start_count, n0);

    $display("[TB] enable dropped in WAIT_RDY with reader not ready");
    i2c_ready = 1'b0;
    en = 1'b1;
    repeat (5) @(negedge clk);
    en = 1'b0;
    repeat (3) @(negedge clk);
    i2c_ready = 1'b1;
    n0 = start_count;
    repeat (20) @(negedge clk);
    checkOutput("no_start_in_idle", start_count, n0);
    en = 1'b1;
    applyStimulus(16'hF000, 20, mk(1'b0, 12'h321, 4'd1, 1'b0, 801), s);

    $display("[TB] asynchronous reset in BUSY");
    wait_start(s, ok);
    i2c_ready = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("async_rst_angle", int'(angle), 0);
    checkOutput("async_rst_fail_cnt", int'(fail_cnt), 0);
    checkOutput("async_rst_err", int'(err), 0);
    checkOutput("async_rst_valid", int'(angle_valid), 0);
    checkOutput("async_rst_delta", int'(angle_delta), 0);
    checkOutput("async_rst_start", int'(i2c_start), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    n0 = start_count;
    repeat (10) @(negedge clk);
    checkOutput("no_start_until_ready", start_count, n0);
    i2c_done   = 1'b1;
    i2c_regout = 16'h0555;
    @(negedge clk);
    i2c_done = 1'b0;
    checkOutput("late_done_after_rst_angle", int'(angle), 0);
    i2c_ready = 1'b1;
    applyStimulus(16'h0FF0, 20, mk(1'b1, 12'hFF0, 4'd0, 1'b0, 0), s);
    applyStimulus(16'h0010, 20, mk(1'b1, 12'h010, 4'd0, 1'b0, 32), s);

    en = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
